// File: rtl/arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// default watchdog limit and watchdog counter width.
package arb_pkg;

    localparam int ARB_TIMEOUT_DEF = 15;
    localparam int ARB_WDOG_W      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_wdog.sv
// Watchdog for the arbiter WAIT states: down-counter reloaded on clear,
// expire is the terminal count seen while enabled.
module arb_wdog
    import arb_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    logic [ARB_WDOG_W-1:0] cnt;

    // Loaded with TIMEOUT-1 so the terminal count lands on the TIMEOUT-th enabled cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= ARB_WDOG_W'(TIMEOUT - 1);
        end else if (en_i && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire_o = en_i && !clr_i && (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port; data wins.
// Define ARB_TIMEOUT_EN to add a watchdog that aborts unacknowledged accesses.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              if_stall_o,
    output logic              dm_stall_o,
    output logic              err_o
);

    arb_state_t state;
    logic       wd_expire;

`ifdef ARB_TIMEOUT_EN
    logic err_q;

    arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (state != IDLE),
        .clr_i    (state == IDLE),
        .expire_o (wd_expire)
    );

    // An ack in the expiring cycle is a normal completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state != IDLE) && !mem_ack_i && wd_expire;
        end
    end

    assign err_o = err_q;
`else
    logic unused_timeout;

    assign wd_expire      = 1'b0;
    assign unused_timeout = ^TIMEOUT;
    assign err_o          = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_done_o   <= 1'b0;
            dm_done_o   <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
        end else begin
            if_done_o <= 1'b0;
            dm_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    // A port whose done is high this cycle is not eligible.
                    if (dm_req_i && !dm_done_o) begin
                        state       <= DM_WAIT;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                    end else if (if_req_i && !if_done_o) begin
                        state       <= IF_WAIT;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= if_addr_i;
                        mem_wdata_o <= '0;
                    end
                end
                IF_WAIT: begin
                    if (mem_ack_i) begin
                        state      <= IDLE;
                        mem_req_o  <= 1'b0;
                        if_done_o  <= 1'b1;
                        if_rdata_o <= mem_rdata_i;
                    end else if (wd_expire) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        if_done_o <= 1'b1;
                    end
                end
                DM_WAIT: begin
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        dm_done_o <= 1'b1;
                        if (!mem_we_o) begin
                            dm_rdata_o <= mem_rdata_i;
                        end
                    end else if (wd_expire) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        dm_done_o <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

    assign if_stall_o = if_req_i && !if_done_o;
    assign dm_stall_o = dm_req_i && !dm_done_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand-written reset and watchdog sequences.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_done_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_done_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        if_stall_o;
    logic        dm_stall_o;
    logic        err_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_done_o   (if_done_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_done_o   (dm_done_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .if_stall_o  (if_stall_o),
        .dm_stall_o  (dm_stall_o),
        .err_o       (err_o)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_ifd;
        logic        e_dmd;
        logic        e_ifs;
        logic        e_dms;
        logic [31:0] e_ifr;
        logic [31:0] e_dmr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic ifq, input logic [31:0] ifa,
        input logic dmq, input logic dmw, input logic [31:0] dma, input logic [31:0] dmd,
        input logic ack, input logic [31:0] rd,
        input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ewd,
        input logic eifd, input logic edmd, input logic eifs, input logic edms,
        input logic [31:0] eifr, input logic [31:0] edmr);
        vec_t v;
        v.if_req = ifq;  v.if_addr = ifa;
        v.dm_req = dmq;  v.dm_we = dmw; v.dm_addr = dma; v.dm_wdata = dmd;
        v.ack = ack;     v.rdata = rd;
        v.e_req = er;    v.e_we = ew;   v.e_addr = ea;   v.e_wdata = ewd;
        v.e_ifd = eifd;  v.e_dmd = edmd; v.e_ifs = eifs; v.e_dms = edms;
        v.e_ifr = eifr;  v.e_dmr = edmr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // single fetch 0x10, ack on cycle 3
        vecs.push_back(mk(1,'h10, 0,0,0,0, 0,0,        0,0,0,0,        0,0,1,0, 0,0));
        vecs.push_back(mk(1,'h10, 0,0,0,0, 0,0,        1,0,'h10,0,     0,0,1,0, 0,0));
        vecs.push_back(mk(1,'h10, 0,0,0,0, 0,0,        1,0,'h10,0,     0,0,1,0, 0,0));
        vecs.push_back(mk(1,'h10, 0,0,0,0, 1,'h1234,   1,0,'h10,0,     0,0,1,0, 0,0));
        vecs.push_back(mk(1,'h10, 0,0,0,0, 0,0,        0,0,0,0,        1,0,0,0, 'h1234,0));
        vecs.push_back(mk(0,0,    0,0,0,0, 0,0,        0,0,0,0,        0,0,0,0, 'h1234,0));
        // simultaneous fetch 0x20 / load 0x40
        vecs.push_back(mk(1,'h20, 1,0,'h40,0, 0,0,     0,0,0,0,        0,0,1,1, 'h1234,0));
        vecs.push_back(mk(1,'h20, 1,0,'h40,0, 1,'hAAAA, 1,0,'h40,0,    0,0,1,1, 'h1234,0));
        vecs.push_back(mk(1,'h20, 1,0,'h40,0, 0,0,     0,0,0,0,        0,1,1,0, 'h1234,'hAAAA));
        vecs.push_back(mk(1,'h20, 0,0,0,0, 1,'hBBBB,   1,0,'h20,0,     0,0,1,0, 'h1234,'hAAAA));
        vecs.push_back(mk(1,'h20, 0,0,0,0, 0,0,        0,0,0,0,        1,0,0,0, 'hBBBB,'hAAAA));
        vecs.push_back(mk(0,0,    0,0,0,0, 0,0,        0,0,0,0,        0,0,0,0, 'hBBBB,'hAAAA));
        // write 0xCAFE to 0x8, immediate ack
        vecs.push_back(mk(0,0, 1,1,'h8,'hCAFE, 0,0,       0,0,0,0,        0,0,0,1, 'hBBBB,'hAAAA));
        vecs.push_back(mk(0,0, 1,1,'h8,'hCAFE, 1,'hDEAD,  1,1,'h8,'hCAFE, 0,0,0,1, 'hBBBB,'hAAAA));
        vecs.push_back(mk(0,0, 1,1,'h8,'hCAFE, 0,0,       0,0,0,0,        0,1,0,0, 'hBBBB,'hAAAA));
        vecs.push_back(mk(0,0, 0,0,0,0,        0,0,       0,0,0,0,        0,0,0,0, 'hBBBB,'hAAAA));
        // back-to-back fetch, req held through done
        vecs.push_back(mk(1,'h30, 0,0,0,0, 0,0,        0,0,0,0,        0,0,1,0, 'hBBBB,'hAAAA));
        vecs.push_back(mk(1,'h30, 0,0,0,0, 1,'h1111,   1,0,'h30,0,     0,0,1,0, 'hBBBB,'hAAAA));
        vecs.push_back(mk(1,'h34, 0,0,0,0, 0,0,        0,0,0,0,        1,0,0,0, 'h1111,'hAAAA));
        vecs.push_back(mk(1,'h34, 0,0,0,0, 0,0,        0,0,0,0,        0,0,1,0, 'h1111,'hAAAA));
        vecs.push_back(mk(1,'h34, 0,0,0,0, 1,'h2222,   1,0,'h34,0,     0,0,1,0, 'h1111,'hAAAA));
        vecs.push_back(mk(0,0,    0,0,0,0, 0,0,        0,0,0,0,        1,0,0,0, 'h2222,'hAAAA));
        // ack while idle is ignored
        vecs.push_back(mk(0,0,    0,0,0,0, 1,'h9999,   0,0,0,0,        0,0,0,0, 'h2222,'hAAAA));
        vecs.push_back(mk(0,0,    0,0,0,0, 0,0,        0,0,0,0,        0,0,0,0, 'h2222,'hAAAA));

        rst_i = 1'b1;
        if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_we_i = 0;
        dm_addr_i = 0; dm_wdata_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
        step();
        step();
        @(negedge clk_i);
        chk("rst mem_req",  32'(mem_req_o), 0);
        chk("rst mem_we",   32'(mem_we_o), 0);
        chk("rst mem_addr", mem_addr_o, 0);
        chk("rst mem_wdata", mem_wdata_o, 0);
        chk("rst if_done",  32'(if_done_o), 0);
        chk("rst dm_done",  32'(dm_done_o), 0);
        chk("rst err",      32'(err_o), 0);
        chk("rst if_rdata", if_rdata_o, 0);
        chk("rst dm_rdata", dm_rdata_o, 0);
        step();
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            if_req_i    = vecs[i].if_req;
            if_addr_i   = vecs[i].if_addr;
            dm_req_i    = vecs[i].dm_req;
            dm_we_i     = vecs[i].dm_we;
            dm_addr_i   = vecs[i].dm_addr;
            dm_wdata_i  = vecs[i].dm_wdata;
            mem_ack_i   = vecs[i].ack;
            mem_rdata_i = vecs[i].rdata;
            @(negedge clk_i);
            chk($sformatf("v%0d mem_req", i), 32'(mem_req_o), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d mem_we", i), 32'(mem_we_o), 32'(vecs[i].e_we));
                chk($sformatf("v%0d mem_addr", i), mem_addr_o, vecs[i].e_addr);
                if (vecs[i].e_we)
                    chk($sformatf("v%0d mem_wdata", i), mem_wdata_o, vecs[i].e_wdata);
            end
            chk($sformatf("v%0d if_done", i), 32'(if_done_o), 32'(vecs[i].e_ifd));
            chk($sformatf("v%0d dm_done", i), 32'(dm_done_o), 32'(vecs[i].e_dmd));
            chk($sformatf("v%0d if_stall", i), 32'(if_stall_o), 32'(vecs[i].e_ifs));
            chk($sformatf("v%0d dm_stall", i), 32'(dm_stall_o), 32'(vecs[i].e_dms));
            chk($sformatf("v%0d if_rdata", i), if_rdata_o, vecs[i].e_ifr);
            chk($sformatf("v%0d dm_rdata", i), dm_rdata_o, vecs[i].e_dmr);
            chk($sformatf("v%0d err", i), 32'(err_o), 0);
            step();
        end
        mem_ack_i = 0;

        // reset in DM_WAIT, ack on the cycle after reset
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 'h50;
        step();
        @(negedge clk_i);
        chk("rw mem_req before rst", 32'(mem_req_o), 1);
        rst_i = 1; dm_req_i = 0;
        step();
        rst_i = 0; mem_ack_i = 1; mem_rdata_i = 'h5555;
        @(negedge clk_i);
        chk("rw mem_req", 32'(mem_req_o), 0);
        chk("rw dm_done", 32'(dm_done_o), 0);
        chk("rw dm_rdata", dm_rdata_o, 0);
        step();
        mem_ack_i = 0;
        @(negedge clk_i);
        chk("rw dm_done after ack", 32'(dm_done_o), 0);
        chk("rw mem_req after ack", 32'(mem_req_o), 0);
        chk("rw dm_rdata after ack", dm_rdata_o, 0);
        chk("rw state", 32'(dut.state), 32'(IDLE));
        step();

`ifdef ARB_TIMEOUT_EN
        // no ack: abort after 4 WAIT cycles
        dm_req_i = 1; dm_addr_i = 'h60;
        for (int c = 1; c <= 4; c++) begin
            step();
            @(negedge clk_i);
            chk($sformatf("to c%0d mem_req", c), 32'(mem_req_o), 1);
            chk($sformatf("to c%0d err", c), 32'(err_o), 0);
        end
        step();
        dm_req_i = 0;
        @(negedge clk_i);
        chk("to mem_req", 32'(mem_req_o), 0);
        chk("to dm_done", 32'(dm_done_o), 1);
        chk("to err", 32'(err_o), 1);
        chk("to dm_rdata", dm_rdata_o, 0);
        step();
        @(negedge clk_i);
        chk("to dm_done end", 32'(dm_done_o), 0);
        chk("to err end", 32'(err_o), 0);
        step();
        // ack on the 4th WAIT cycle wins over the timeout
        dm_req_i = 1; dm_addr_i = 'h64;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 4) begin
                mem_ack_i = 1; mem_rdata_i = 'h7777;
            end
        end
        step();
        mem_ack_i = 0; dm_req_i = 0;
        @(negedge clk_i);
        chk("ta dm_done", 32'(dm_done_o), 1);
        chk("ta err", 32'(err_o), 0);
        chk("ta dm_rdata", dm_rdata_o, 'h7777);
        chk("ta mem_req", 32'(mem_req_o), 0);
        step();
`else
        // without the watchdog WAIT lasts until ack
        dm_req_i = 1; dm_addr_i = 'h70;
        for (int c = 1; c <= 20; c++) begin
            step();
            @(negedge clk_i);
            chk($sformatf("nw c%0d mem_req", c), 32'(mem_req_o), 1);
            chk($sformatf("nw c%0d err", c), 32'(err_o), 0);
        end
        step();
        mem_ack_i = 1; mem_rdata_i = 'h4242;
        step();
        mem_ack_i = 0; dm_req_i = 0;
        @(negedge clk_i);
        chk("nw dm_done", 32'(dm_done_o), 1);
        chk("nw dm_rdata", dm_rdata_o, 'h4242);
        chk("nw err", 32'(err_o), 0);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
